// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the seq_mult shift-and-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration counter width: must hold 0..WIDTH-1 with headroom.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM and iteration counter for seq_mult; issues load/step/finish strobes.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic out_ready_i,
  input  logic early_done_i,
  output logic in_ready_o,
  output logic busy_o,
  output logic out_valid_o,
  output logic load_o,
  output logic step_o,
  output logic finish_o
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic               last_c;

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q == RUN);
  assign out_valid_o = (state_q == DONE);

  assign last_c   = (count_q == CNT_W'(WIDTH - 1));
  assign load_o   = in_valid_i && (state_q == IDLE);
  assign step_o   = (state_q == RUN);
  assign finish_o = step_o && (last_c || early_done_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_o) begin
            state_q <= RUN;
            count_q <= '0;
          end
        end
        RUN: begin
          count_q <= count_q + CNT_W'(1);
          if (finish_o) state_q <= DONE;
        end
        DONE: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional SEQ_MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [PW-1:0]    sum_c;
  logic             load_c, step_c, finish_c, early_done_c;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  // Next multiplier value (after this edge's shift) carries no more set bits.
  assign early_done_c = (mplier_q[WIDTH-1:1] == '0);
`else
  assign early_done_c = 1'b0;
`endif

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .out_ready_i  (out_ready),
    .early_done_i (early_done_c),
    .in_ready_o   (in_ready),
    .busy_o       (busy),
    .out_valid_o  (out_valid),
    .load_o       (load_c),
    .step_o       (step_c),
    .finish_o     (finish_c)
  );

  assign sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    if (load_c) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (step_c) begin
      acc_d    = sum_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      if (finish_c) product_d = sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule
